// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: EX instruction kinds,
// BTB counter constants and the 2-bit saturating counter update.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    EX_KIND_NONE   = 2'b00,
    EX_KIND_BRANCH = 2'b01,
    EX_KIND_JUMP   = 2'b10,
    EX_KIND_RSVD   = 2'b11
  } ex_kind_e;

  localparam int unsigned CNT_W     = 2;
  localparam logic [1:0]  CNT_RESET = 2'b01;

  function automatic logic [CNT_W-1:0] cnt_update(input logic [CNT_W-1:0] cnt,
                                                  input logic             taken);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (taken && cnt != '1)
      nxt = cnt + 1'b1;
    else if (!taken && cnt != '0)
      nxt = cnt - 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_btb_table.sv
// Direct-mapped BTB storage: async read for IF, async read plus sync write
// for EX training, async active-low clear of every entry.
module btb_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned IDX_BITS  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [IDX_BITS-1:0]           if_idx,
  output logic                          if_valid,
  output logic [WORD_SIZE-IDX_BITS-1:0] if_tag,
  output logic [WORD_SIZE-1:0]          if_target,
  output logic [CNT_W-1:0]              if_cnt,
  output logic                          if_jump,
  input  logic [IDX_BITS-1:0]           ex_idx,
  output logic                          ex_valid,
  output logic [WORD_SIZE-IDX_BITS-1:0] ex_tag,
  output logic [WORD_SIZE-1:0]          ex_target,
  output logic [CNT_W-1:0]              ex_cnt,
  output logic                          ex_jump,
  input  logic                          wr_en,
  input  logic [WORD_SIZE-IDX_BITS-1:0] wr_tag,
  input  logic [WORD_SIZE-1:0]          wr_target,
  input  logic [CNT_W-1:0]              wr_cnt,
  input  logic                          wr_jump
);

  localparam int unsigned TAG_W   = WORD_SIZE - IDX_BITS;
  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  logic                 valid_q  [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]     cnt_q    [ENTRIES];
  logic                 jump_q   [ENTRIES];

  assign if_valid  = valid_q[if_idx];
  assign if_tag    = tag_q[if_idx];
  assign if_target = target_q[if_idx];
  assign if_cnt    = cnt_q[if_idx];
  assign if_jump   = jump_q[if_idx];

  assign ex_valid  = valid_q[ex_idx];
  assign ex_tag    = tag_q[ex_idx];
  assign ex_target = target_q[ex_idx];
  assign ex_cnt    = cnt_q[ex_idx];
  assign ex_jump   = jump_q[ex_idx];

  // The EX write index is always the EX read index; every write leaves the entry valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RESET;
        jump_q[i]   <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= wr_tag;
      target_q[ex_idx] <= wr_target;
      cnt_q[ex_idx]    <= wr_cnt;
      jump_q[ex_idx]   <= wr_jump;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-side branch resolution: mispredict flush/redirect, BTB prediction for IF,
// BTB training at resolution and saturating branch/mispredict statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned IDX_BITS  = 4,
  parameter logic [1:0]  CNT_ALLOC = 2'b10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] if_pc,
  output logic [WORD_SIZE-1:0] if_pred_pc,
  output logic                 if_pred_taken,
  input  logic                 ex_valid,
  input  logic                 ex_stall,
  input  logic [WORD_SIZE-1:0] ex_pc,
  input  logic [1:0]           ex_kind,
  input  logic [WORD_SIZE-1:0] ex_pred_pc,
  input  logic [WORD_SIZE-1:0] ex_real_pc,
  output logic                 flush,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic [15:0]          branch_count,
  output logic [15:0]          mispredict_count
);

  localparam int unsigned TAG_W = WORD_SIZE - IDX_BITS;

  logic                 if_e_valid, if_e_jump;
  logic [TAG_W-1:0]     if_e_tag;
  logic [WORD_SIZE-1:0] if_e_target;
  logic [CNT_W-1:0]     if_e_cnt;
  logic                 ex_e_valid, ex_e_jump;
  logic [TAG_W-1:0]     ex_e_tag;
  logic [WORD_SIZE-1:0] ex_e_target;
  logic [CNT_W-1:0]     ex_e_cnt;

  logic                 wr_en, wr_jump;
  logic [TAG_W-1:0]     wr_tag;
  logic [WORD_SIZE-1:0] wr_target;
  logic [CNT_W-1:0]     wr_cnt;

  logic                 if_hit, ex_hit, res, taken;
  logic [WORD_SIZE-1:0] ex_seq_pc;
  ex_kind_e             kind;

  btb_table #(
    .WORD_SIZE (WORD_SIZE),
    .IDX_BITS  (IDX_BITS)
  ) u_btb (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_idx    (if_pc[IDX_BITS-1:0]),
    .if_valid  (if_e_valid),
    .if_tag    (if_e_tag),
    .if_target (if_e_target),
    .if_cnt    (if_e_cnt),
    .if_jump   (if_e_jump),
    .ex_idx    (ex_pc[IDX_BITS-1:0]),
    .ex_valid  (ex_e_valid),
    .ex_tag    (ex_e_tag),
    .ex_target (ex_e_target),
    .ex_cnt    (ex_e_cnt),
    .ex_jump   (ex_e_jump),
    .wr_en     (wr_en),
    .wr_tag    (wr_tag),
    .wr_target (wr_target),
    .wr_cnt    (wr_cnt),
    .wr_jump   (wr_jump)
  );

  assign if_hit        = if_e_valid && (if_e_tag == if_pc[WORD_SIZE-1:IDX_BITS]);
  assign if_pred_taken = if_hit && (if_e_jump || if_e_cnt[1]);
  assign if_pred_pc    = if_pred_taken ? if_e_target : if_pc + WORD_SIZE'(1);

  assign kind      = ex_kind_e'(ex_kind);
  assign res       = ex_valid && !ex_stall;
  assign ex_seq_pc = ex_pc + WORD_SIZE'(1);
  assign taken     = (ex_real_pc != ex_seq_pc);
  assign ex_hit    = ex_e_valid && (ex_e_tag == ex_pc[WORD_SIZE-1:IDX_BITS]);

  // reset_n gating drops a pending flush the moment reset asserts.
  assign flush       = reset_n && res && (ex_real_pc != ex_pred_pc);
  assign redirect_pc = reset_n ? ex_real_pc : '0;

  always_comb begin
    wr_en     = 1'b0;
    wr_tag    = ex_pc[WORD_SIZE-1:IDX_BITS];
    wr_target = ex_e_target;
    wr_cnt    = ex_e_cnt;
    wr_jump   = ex_e_jump;
    if (res) begin
      unique case (kind)
        EX_KIND_BRANCH: begin
          if (ex_hit) begin
            wr_en  = 1'b1;
            wr_cnt = cnt_update(ex_e_cnt, taken);
            if (taken) wr_target = ex_real_pc;
          end else if (taken) begin
            wr_en     = 1'b1;
            wr_target = ex_real_pc;
            wr_cnt    = CNT_ALLOC;
            wr_jump   = 1'b0;
          end
        end
        EX_KIND_JUMP: begin
          wr_en     = 1'b1;
          wr_target = ex_real_pc;
          wr_jump   = 1'b1;
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (res && kind != EX_KIND_NONE && branch_count != '1)
        branch_count <= branch_count + 16'd1;
      if (flush && mispredict_count != '1)
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule
